// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcode/funct encodings, MDU op codes and the
// per-stage decode used by the hazard scheduler.
package mips_defs;

   localparam int MULT_LAT_DFLT = 5;
   localparam int DIV_LAT_DFLT  = 10;
   localparam int CNT_W_DFLT    = 4;

   typedef enum logic [5:0] {
      OP_SPECIAL = 6'h00, OP_BEQ  = 6'h04, OP_BNE   = 6'h05, OP_BLEZ  = 6'h06,
      OP_BGTZ    = 6'h07, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a,
      OP_SLTIU   = 6'h0b, OP_ANDI = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e,
      OP_LUI     = 6'h0f, OP_LB   = 6'h20, OP_LH    = 6'h21, OP_LW    = 6'h23,
      OP_LBU     = 6'h24, OP_LHU  = 6'h25, OP_SB    = 6'h28, OP_SH    = 6'h29,
      OP_SW      = 6'h2b
   } opcode_e;

   typedef enum logic [5:0] {
      FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
      FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09,
      FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13,
      FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1a, FN_DIVU = 6'h1b,
      FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
      FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
      FN_SLT  = 6'h2a, FN_SLTU  = 6'h2b
   } funct_e;

   // Low two funct bits of the mult family map directly onto these.
   typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

   typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

   typedef struct packed {
      logic       calc_r;
      logic       calc_i;
      logic       load;
      logic       store;
      logic       branch;
      logic       jr;
      logic       md;
      logic       hilo;
      logic [1:0] md_op;
      logic [4:0] rs;
      logic [4:0] rt;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] instr);
      dec_t d;
      d       = '0;
      d.rs    = instr[25:21];
      d.rt    = instr[20:16];
      d.md_op = instr[1:0];
      if (opcode_e'(instr[31:26]) == OP_SPECIAL) begin
         case (funct_e'(instr[5:0]))
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_XOR, FN_NOR, FN_SLT, FN_SLTU:         d.calc_r = 1'b1;
            FN_JR, FN_JALR:                          d.jr     = 1'b1;
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO:      d.hilo   = 1'b1;
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:      d.md     = 1'b1;
            default: ;
         endcase
      end else begin
         case (opcode_e'(instr[31:26]))
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:        d.calc_i = 1'b1;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:     d.load   = 1'b1;
            OP_SB, OP_SH, OP_SW:                     d.store  = 1'b1;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:        d.branch = 1'b1;
            default: ;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/md_seq.sv
// Mult/div unit sequencer: IDLE/BUSY FSM plus a down-counter that times
// the operation from the start pulse to the HI/LO write.
module md_seq
   import mips_defs::*;
#(
   parameter int MULT_LAT = MULT_LAT_DFLT,
   parameter int DIV_LAT  = DIV_LAT_DFLT,
   parameter int CNT_W    = CNT_W_DFLT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_ex_md,
   input  logic [1:0] i_ex_op,
   input  logic       i_flush,
   output logic       o_start,
   output logic [1:0] o_op,
   output logic       o_busy,
   output logic       o_done
);

   md_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_start     = 1'b0;
      o_op        = 2'b00;
      case (r_state)
         MD_IDLE: begin
            if (i_ex_md && !i_flush && !reset) begin
               o_start     = 1'b1;
               o_op        = i_ex_op;
               w_cnt_nxt   = (md_op_e'(i_ex_op) inside {MD_DIV, MD_DIVU}) ?
                             CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
               w_state_nxt = MD_BUSY;
            end
         end
         MD_BUSY: begin
            if (r_cnt == '0) w_state_nxt = MD_IDLE;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         default: w_state_nxt = MD_IDLE;
      endcase
   end

   assign o_busy = (r_state == MD_BUSY);
   assign o_done = o_busy && (r_cnt == '0);

   // The ID-stage stall keeps a second mult-family op out of EX while busy.
   a_no_start_while_busy: assert property (
      @(posedge clk) disable iff (reset) !(o_busy && i_ex_md && !i_flush));

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: combinational stall for load-use, branch-operand
// and MDU hazards, plus the md_seq instance that owns MDU timing.
module hazard_sched
   import mips_defs::*;
#(
   parameter int MULT_LAT = MULT_LAT_DFLT,
   parameter int DIV_LAT  = DIV_LAT_DFLT,
   parameter int CNT_W    = CNT_W_DFLT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_ID,
   input  logic [31:0] Instr_EX,
   input  logic [31:0] Instr_MEM,
   input  logic [4:0]  RegA3_EX,
   input  logic [4:0]  RegA3_MEM,
   input  logic        ExcFlush,
   output logic        Stall,
   output logic        MD_Start,
   output logic [1:0]  MD_Op,
   output logic        MD_Busy,
   output logic        MD_Done
);

   dec_t w_dec_id, w_dec_ex, w_dec_mem;
   logic w_id_use_rs, w_id_use_rt;
   logic w_ex_hit_rs, w_ex_hit_rt, w_mem_hit_rs, w_mem_hit_rt;
   logic w_load_use, w_branch_haz, w_md_haz;
   logic w_unused_dec;

   assign w_dec_id  = decode(Instr_ID);
   assign w_dec_ex  = decode(Instr_EX);
   assign w_dec_mem = decode(Instr_MEM);

   assign w_id_use_rs = w_dec_id.calc_r | w_dec_id.calc_i | w_dec_id.load |
                        w_dec_id.store  | w_dec_id.branch | w_dec_id.jr;
   assign w_id_use_rt = w_dec_id.calc_r | w_dec_id.store  | w_dec_id.branch;

   // Register 0 is never a real producer, so it can never match.
   assign w_ex_hit_rs  = (RegA3_EX  != 5'd0) && (RegA3_EX  == w_dec_id.rs);
   assign w_ex_hit_rt  = (RegA3_EX  != 5'd0) && (RegA3_EX  == w_dec_id.rt);
   assign w_mem_hit_rs = (RegA3_MEM != 5'd0) && (RegA3_MEM == w_dec_id.rs);
   assign w_mem_hit_rt = (RegA3_MEM != 5'd0) && (RegA3_MEM == w_dec_id.rt);

   assign w_load_use = w_dec_ex.load &&
                       ((w_id_use_rs && w_ex_hit_rs) || (w_id_use_rt && w_ex_hit_rt));

   // Branches resolve in ID, so even an ALU result in EX is too late.
   assign w_branch_haz = (w_dec_id.branch | w_dec_id.jr) &&
      (((w_dec_ex.calc_r | w_dec_ex.calc_i | w_dec_ex.load) && (w_ex_hit_rs || w_ex_hit_rt)) ||
       (w_dec_mem.load && (w_mem_hit_rs || w_mem_hit_rt)));

   assign w_md_haz = (w_dec_id.md | w_dec_id.hilo) && (MD_Busy | MD_Start);

   assign Stall = !ExcFlush && !reset && (w_load_use || w_branch_haz || w_md_haz);

   assign w_unused_dec = ^{w_dec_id.md_op, w_dec_ex, w_dec_mem};

   md_seq #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) u_md_seq (
      .clk     (clk),
      .reset   (reset),
      .i_ex_md (w_dec_ex.md),
      .i_ex_op (w_dec_ex.md_op),
      .i_flush (ExcFlush),
      .o_start (MD_Start),
      .o_op    (MD_Op),
      .o_busy  (MD_Busy),
      .o_done  (MD_Done)
   );

endmodule
